// File: rtl/inst_loader.sv
// inst_loader: byte-stream programmer for the instruction store.
// Receives a frame of {count, count*4 data bytes (MSB first), xor checksum}
// and writes big-endian 32-bit words into the instruction RAM, holding the
// CPU until the image is complete and verified.
module inst_loader #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned NW = $clog2(DEPTH + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  logic [1:0]    rst_sync;
  logic          rst_int_n;
  state_t        state;
  state_t        nxt;
  logic [1:0]    code_n;
  logic          accept;
  logic          wait_st;
  logic          tmo;
  logic [NW-1:0] cnt;
  logic [NW-1:0] idx;
  logic [1:0]    bidx;
  logic [23:0]   shift;
  logic [7:0]    csum;
  logic [TW-1:0] tcnt;

  // Reset asserts immediately and releases two clean edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  // Next-state and abort-cause decode.
  always_comb begin
    accept  = byte_valid && byte_ready;
    wait_st = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
    tmo     = (TIMEOUT != 0) && wait_st && !accept && (tcnt == TLIM);
    nxt     = state;
    code_n  = err_code;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          nxt    = S_COUNT;
          code_n = '0;
        end
      end
      S_COUNT: begin
        if (accept) begin
          if ((byte_data == '0) || (32'(byte_data) > DEPTH)) begin
            nxt    = S_ERR;
            code_n = 2'b01;
          end else begin
            nxt = S_DATA;
          end
        end else if (tmo) begin
          nxt    = S_ERR;
          code_n = 2'b11;
        end
      end
      S_DATA: begin
        if (accept) begin
          if (bidx == 2'd3) begin
            nxt = S_WRITE;
          end
        end else if (tmo) begin
          nxt    = S_ERR;
          code_n = 2'b11;
        end
      end
      S_WRITE: begin
        nxt = (idx == cnt - NW'(1)) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (accept) begin
          if (byte_data == csum) begin
            nxt = S_DONE;
          end else begin
            nxt    = S_ERR;
            code_n = 2'b10;
          end
        end else if (tmo) begin
          nxt    = S_ERR;
          code_n = 2'b11;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // State register, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
      cnt        <= '0;
      idx        <= '0;
      bidx       <= '0;
      shift      <= '0;
      csum       <= '0;
      tcnt       <= '0;
    end else begin
      state      <= nxt;
      err_code   <= code_n;
      byte_ready <= (nxt == S_COUNT) || (nxt == S_DATA) || (nxt == S_CHECK);
      busy       <= (nxt == S_COUNT) || (nxt == S_DATA) || (nxt == S_WRITE) ||
                    (nxt == S_CHECK);
      cpu_hold   <= (nxt == S_COUNT) || (nxt == S_DATA) || (nxt == S_WRITE) ||
                    (nxt == S_CHECK) || (nxt == S_ERR);
      done       <= (nxt == S_DONE);
      err        <= (nxt == S_ERR);
      mem_we     <= (nxt == S_WRITE);

      if (wait_st) begin
        tcnt <= accept ? '0 : tcnt + TW'(1);
      end

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            bidx <= '0;
            idx  <= '0;
            csum <= '0;
            tcnt <= '0;
          end
        end
        S_COUNT: begin
          if (accept) begin
            cnt <= NW'(byte_data);
          end
        end
        S_DATA: begin
          if (accept) begin
            shift <= {shift[15:0], byte_data};
            csum  <= csum ^ byte_data;
            bidx  <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              mem_wdata <= {shift, byte_data};
              mem_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
            end
          end
        end
        S_WRITE: begin
          idx <= idx + NW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Testbench for inst_loader: table-driven frames plus hand-written timeout,
// address-wrap and mid-load reset sequences, with a write scoreboard per DUT.
module tb_inst_loader;

  localparam int unsigned AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n_s [2];
  logic          start_s [2];
  logic          valid_s [2];
  logic [7:0]    data_s  [2];
  logic          ready_s [2];
  logic          we_s    [2];
  logic [AW-1:0] addr_s  [2];
  logic [31:0]   wdata_s [2];
  logic          hold_s  [2];
  logic          busy_s  [2];
  logic          done_s  [2];
  logic          err_s   [2];
  logic [1:0]    code_s  [2];

  int total = 0;
  int bad   = 0;

  logic [37:0] exp_q0[$];
  logic [37:0] exp_q1[$];
  logic        prev_we[2];
  logic [37:0] e_mon;
  bit          got_mon;

  inst_loader #(.DEPTH(64), .ADDR_W(AW), .BASE_ADDR(0), .TIMEOUT(16)) dut0 (
    .clk(clk), .rst_n(rst_n_s[0]), .start(start_s[0]), .byte_valid(valid_s[0]),
    .byte_data(data_s[0]), .byte_ready(ready_s[0]), .mem_we(we_s[0]),
    .mem_addr(addr_s[0]), .mem_wdata(wdata_s[0]), .cpu_hold(hold_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0]), .err_code(code_s[0])
  );

  inst_loader #(.DEPTH(64), .ADDR_W(AW), .BASE_ADDR(62), .TIMEOUT(16)) dut1 (
    .clk(clk), .rst_n(rst_n_s[1]), .start(start_s[1]), .byte_valid(valid_s[1]),
    .byte_data(data_s[1]), .byte_ready(ready_s[1]), .mem_we(we_s[1]),
    .mem_addr(addr_s[1]), .mem_wdata(wdata_s[1]), .cpu_hold(hold_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1]), .err_code(code_s[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of that DUT's scoreboard.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (we_s[s]) begin
        check("we_single_cycle", 64'(prev_we[s]), 64'd0);
        check("ready_low_in_write", 64'(ready_s[s]), 64'd0);
        got_mon = 1'b0;
        if (s == 0) begin
          if (exp_q0.size() != 0) begin e_mon = exp_q0.pop_front(); got_mon = 1'b1; end
        end else begin
          if (exp_q1.size() != 0) begin e_mon = exp_q1.pop_front(); got_mon = 1'b1; end
        end
        if (!got_mon) begin
          total++;
          bad++;
          $display("FAIL unexpected_write dut%0d: got addr %0h data %0h expected none",
                   s, addr_s[s], wdata_s[s]);
        end else begin
          check("write_addr", 64'(addr_s[s]), 64'(e_mon[37:32]));
          check("write_data", 64'(wdata_s[s]), 64'(e_mon[31:0]));
        end
      end
      prev_we[s] = we_s[s];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] word_of(input logic [31:0] w0, input logic [31:0] w1,
                                           input int i);
    if (i == 0) return w0;
    if (i == 1) return w1;
    return w0 ^ (32'(i) * 32'h9E3779B9);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input int s, input logic [7:0] b, input bit rnd);
    bit sent = 1'b0;
    int k = 0;
    data_s[s] = b;
    while (!sent && k < 100) begin
      valid_s[s] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (valid_s[s] && ready_s[s]) sent = 1'b1;
      @(negedge clk);
      k++;
    end
    valid_s[s] = 1'b0;
    if (!sent) begin
      total++;
      bad++;
      $display("FAIL byte_handshake dut%0d: byte %0h not accepted expected accept", s, b);
    end
  endtask

  task automatic pulse_start(input int s);
    start_s[s] = 1'b1;
    @(negedge clk);
    start_s[s] = 1'b0;
  endtask

  task automatic push_exp(input int s, input logic [37:0] v);
    if (s == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  // Full frame: start, count, words, checksum (xor-ed with flip).
  task automatic send_frame(input int s, input int n, input logic [31:0] w0,
                            input logic [31:0] w1, input logic [7:0] flip,
                            input bit rnd, input int base);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = '0;
    pulse_start(s);
    send_byte(s, 8'(n), rnd);
    for (int wi = 0; wi < n; wi++) begin
      w = word_of(w0, w1, wi);
      push_exp(s, {AW'(base + wi), w});
      for (int k = 3; k >= 0; k--) begin
        send_byte(s, w[k*8 +: 8], rnd);
        cs = cs ^ w[k*8 +: 8];
      end
    end
    send_byte(s, cs ^ flip, rnd);
  endtask

  typedef struct {
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  flip;
    bit          rnd;
    bit          exp_done;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t tab[7];

  initial begin
    tab[0] = '{2,  32'h00101464, 32'h40000422, 8'h00, 1'b0, 1'b1, 2'b00};
    tab[1] = '{2,  32'h00101464, 32'h40000422, 8'h01, 1'b0, 1'b0, 2'b10};
    tab[2] = '{0,  32'h0,        32'h0,        8'h00, 1'b0, 1'b0, 2'b01};
    tab[3] = '{65, 32'h0,        32'h0,        8'h00, 1'b0, 1'b0, 2'b01};
    tab[4] = '{2,  32'h00101464, 32'h40000422, 8'h00, 1'b1, 1'b1, 2'b00};
    tab[5] = '{1,  32'hDEADBEEF, 32'h0,        8'h00, 1'b1, 1'b1, 2'b00};
    tab[6] = '{64, 32'h12345678, 32'h9ABCDEF0, 8'h00, 1'b0, 1'b1, 2'b00};

    for (int s = 0; s < 2; s++) begin
      rst_n_s[s] = 1'b1;
      start_s[s] = 1'b0;
      valid_s[s] = 1'b0;
      data_s[s]  = '0;
      prev_we[s] = 1'b0;
    end
    #3;
    rst_n_s[0] = 1'b0;
    rst_n_s[1] = 1'b0;
    #1;
    check("rst_ready", 64'(ready_s[0]), 64'd0);
    check("rst_we",    64'(we_s[0]),    64'd0);
    check("rst_hold",  64'(hold_s[0]),  64'd0);
    check("rst_busy",  64'(busy_s[0]),  64'd0);
    check("rst_done",  64'(done_s[0]),  64'd0);
    check("rst_err",   64'(err_s[0]),   64'd0);
    check("rst_code",  64'(code_s[0]),  64'd0);
    repeat (3) @(negedge clk);
    rst_n_s[0] = 1'b1;
    rst_n_s[1] = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_busy",  64'(busy_s[0]),  64'd0);
    check("idle_ready", 64'(ready_s[0]), 64'd0);

    // Table of frames on the base-0 loader.
    for (int i = 0; i < 7; i++) begin
      if (tab[i].exp_code == 2'b01) begin
        pulse_start(0);
        send_byte(0, 8'(tab[i].n), 1'b0);
        check("badcount_err",   64'(err_s[0]),   64'd1);
        check("badcount_code",  64'(code_s[0]),  64'd1);
        check("badcount_ready", 64'(ready_s[0]), 64'd0);
      end else begin
        send_frame(0, tab[i].n, tab[i].w0, tab[i].w1, tab[i].flip, tab[i].rnd, 0);
      end
      @(negedge clk);
      check("done",     64'(done_s[0]), 64'(tab[i].exp_done));
      check("err",      64'(err_s[0]),  64'(tab[i].exp_code != 2'b00));
      check("err_code", 64'(code_s[0]), 64'(tab[i].exp_code));
      check("cpu_hold", 64'(hold_s[0]), 64'(!tab[i].exp_done));
      check("busy",     64'(busy_s[0]), 64'd0);
      check("sb_empty", 64'(exp_q0.size()), 64'd0);
    end

    // Timeout after 3 data bytes, then a clean restart.
    pulse_start(0);
    send_byte(0, 8'd2, 1'b0);
    send_byte(0, 8'h00, 1'b0);
    send_byte(0, 8'h10, 1'b0);
    send_byte(0, 8'h14, 1'b0);
    repeat (15) @(negedge clk);
    check("tmo_not_yet_err",  64'(err_s[0]),  64'd0);
    check("tmo_not_yet_busy", 64'(busy_s[0]), 64'd1);
    @(negedge clk);
    check("tmo_err",  64'(err_s[0]),  64'd1);
    check("tmo_code", 64'(code_s[0]), 64'd3);
    check("tmo_hold", 64'(hold_s[0]), 64'd1);
    send_frame(0, 2, 32'h00101464, 32'h40000422, 8'h00, 1'b0, 0);
    @(negedge clk);
    check("restart_done", 64'(done_s[0]), 64'd1);
    check("restart_err",  64'(err_s[0]),  64'd0);
    check("restart_code", 64'(code_s[0]), 64'd0);
    check("restart_hold", 64'(hold_s[0]), 64'd0);

    // Address wrap on the base-62 loader.
    send_frame(1, 4, 32'hA1A2A3A4, 32'hB1B2B3B4, 8'h00, 1'b0, 62);
    @(negedge clk);
    check("wrap_done", 64'(done_s[1]), 64'd1);
    check("wrap_sb_empty", 64'(exp_q1.size()), 64'd0);

    // Reset after the second write of a 4-word frame.
    pulse_start(1);
    send_byte(1, 8'd4, 1'b0);
    push_exp(1, {AW'(62), 32'h01234567});
    push_exp(1, {AW'(63), 32'h89ABCDEF});
    send_byte(1, 8'h01, 1'b0);
    send_byte(1, 8'h23, 1'b0);
    send_byte(1, 8'h45, 1'b0);
    send_byte(1, 8'h67, 1'b0);
    send_byte(1, 8'h89, 1'b0);
    send_byte(1, 8'hAB, 1'b0);
    send_byte(1, 8'hCD, 1'b0);
    send_byte(1, 8'hEF, 1'b0);
    @(negedge clk);
    rst_n_s[1] = 1'b0;
    #1;
    check("midrst_ready", 64'(ready_s[1]), 64'd0);
    check("midrst_we",    64'(we_s[1]),    64'd0);
    check("midrst_addr",  64'(addr_s[1]),  64'd0);
    check("midrst_wdata", 64'(wdata_s[1]), 64'd0);
    check("midrst_hold",  64'(hold_s[1]),  64'd0);
    check("midrst_busy",  64'(busy_s[1]),  64'd0);
    check("midrst_done",  64'(done_s[1]),  64'd0);
    check("midrst_err",   64'(err_s[1]),   64'd0);
    check("midrst_code",  64'(code_s[1]),  64'd0);
    @(negedge clk);
    valid_s[1] = 1'b1;
    data_s[1]  = 8'h55;
    repeat (3) @(negedge clk);
    rst_n_s[1] = 1'b1;
    repeat (6) @(negedge clk);
    valid_s[1] = 1'b0;
    check("postrst_busy", 64'(busy_s[1]), 64'd0);
    check("postrst_hold", 64'(hold_s[1]), 64'd0);
    check("postrst_sb_empty", 64'(exp_q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
